// File: rtl/inbuf.sv
// Per-input-port wormhole buffer: FIFO of flits plus a route lock held from head to tail.
// Optional macro INBUF_ERR_CHECK_EN enables the sticky protocol-error flag.
module inbuf #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [1:0]        in_type,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [4:0]        req,
  input  logic              grt,
  output logic              out_valid,
  output logic [1:0]        out_type,
  output logic [DATA_W-1:0] out_data,
  output logic [4:0]        out_port,
  output logic              err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] T_HEAD   = 2'b00;
  localparam logic [1:0] T_SINGLE = 2'b11;

  typedef enum logic {IDLE, LOCKED} state_t;

  logic [1:0]        type_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]  count_reg;
  state_t            state_reg, state_next;
  logic [4:0]        route_reg, route_next;

  logic              out_valid_reg;
  logic [1:0]        out_type_reg;
  logic [DATA_W-1:0] out_data_reg;
  logic [4:0]        out_port_reg;

  logic              full, empty, push, pop, fwd, discard;
  logic [4:0]        req_int;
  logic [1:0]        head_type;
  logic [DATA_W-1:0] head_data;
  logic [4:0]        head_port;

  assign full      = (count_reg == CNT_W'(DEPTH));
  assign empty     = (count_reg == '0);
  assign in_ready  = ~full;
  assign push      = in_valid & ~full;
  assign head_type = type_mem[rd_ptr_reg];
  assign head_data = data_mem[rd_ptr_reg];
  assign head_port = head_data[4:0];
  assign pop       = fwd | discard;

  // IDLE inspects the FIFO head: a routable head locks, anything else is dropped.
  always_comb begin
    state_next = state_reg;
    route_next = route_reg;
    req_int    = '0;
    fwd        = 1'b0;
    discard    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!empty) begin
          if ((head_type == T_HEAD || head_type == T_SINGLE) && head_port != '0) begin
            route_next = head_port;
            state_next = LOCKED;
          end else begin
            discard = 1'b1;
          end
        end
      end
      LOCKED: begin
        if (!empty) req_int = route_reg;
        fwd = (req_int != '0) & grt;
        // tail (10) and single (11) both close the packet
        if (fwd && head_type[1]) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign req = req_int;

  always_ff @(posedge clk) begin
    if (push) begin
      type_mem[wr_ptr_reg] <= in_type;
      data_mem[wr_ptr_reg] <= in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      state_reg     <= IDLE;
      route_reg     <= '0;
      out_valid_reg <= 1'b0;
      out_type_reg  <= '0;
      out_data_reg  <= '0;
      out_port_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      route_reg     <= route_next;
      out_valid_reg <= fwd;
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
      if (fwd) begin
        out_type_reg <= head_type;
        out_data_reg <= head_data;
        out_port_reg <= route_reg;
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign out_type  = out_type_reg;
  assign out_data  = out_data_reg;
  assign out_port  = out_port_reg;

`ifdef INBUF_ERR_CHECK_EN
  logic err_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              err_reg <= 1'b0;
    else if ((in_valid & full) | discard) err_reg <= 1'b1;
  end

  assign err = err_reg;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_inbuf.sv
// Directed bench for inbuf: queue-based packet model checked every cycle, plus literal checks per scenario.
module tb_inbuf;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 32;
`ifdef INBUF_ERR_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic [1:0]        in_type;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic [4:0]        req;
  logic              grt;
  logic              out_valid;
  logic [1:0]        out_type;
  logic [DATA_W-1:0] out_data;
  logic [4:0]        out_port;
  logic              err;

  inbuf #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_type(in_type), .in_data(in_data),
    .in_ready(in_ready), .req(req), .grt(grt), .out_valid(out_valid), .out_type(out_type),
    .out_data(out_data), .out_port(out_port), .err(err)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Behavioural model: packet queue + lock flag
  typedef struct packed { logic [1:0] t; logic [31:0] d; } flit_t;
  typedef struct packed { logic [1:0] t; logic [31:0] d; logic [4:0] p; logic [31:0] c; } fwd_t;

  flit_t       mq[$];
  bit          m_locked;
  logic [4:0]  m_route;
  logic        m_ov, m_err;
  logic [1:0]  m_ot;
  logic [31:0] m_od;
  logic [4:0]  m_op;

  fwd_t log_q[$];
  int   req_cnt = 0;

  task automatic model_reset();
    mq.delete();
    m_locked = 1'b0; m_route = '0;
    m_ov = 1'b0; m_ot = '0; m_od = '0; m_op = '0; m_err = 1'b0;
  endtask

  initial model_reset();

  always @(negedge clk) begin
    logic [63:0] got, exp;
    logic [4:0]  ereq;
    flit_t       f;
    bit          was_full;
    if (rst) model_reset();
    ereq = (m_locked && mq.size() > 0) ? m_route : 5'b0;
    exp = 64'({mq.size() < DEPTH, ereq, m_ov, m_ot, m_od, m_op, m_err});
    got = 64'({in_ready, req, out_valid, out_type, out_data, out_port, err});
    check("per-cycle {rdy,req,ov,type,data,port,err}", got, exp);
    if (out_valid) begin
      log_q.push_back('{t: out_type, d: out_data, p: out_port, c: cyc});
      $display("[TB] fwd cyc=%0d type=%b data=%h port=%b", cyc, out_type, out_data, out_port);
    end
    if (req != 5'b0) req_cnt++;
    if (!rst) begin
      was_full = (mq.size() == DEPTH);
      m_ov = 1'b0;
      if (mq.size() > 0) begin
        f = mq[0];
        if (m_locked) begin
          if (grt) begin
            void'(mq.pop_front());
            m_ov = 1'b1; m_ot = f.t; m_od = f.d; m_op = m_route;
            if (f.t == 2'b10 || f.t == 2'b11) m_locked = 1'b0;
          end
        end else if ((f.t == 2'b00 || f.t == 2'b11) && f.d[4:0] != 5'b0) begin
          m_locked = 1'b1;
          m_route  = f.d[4:0];
        end else begin
          void'(mq.pop_front());
          if (ERR_EN) m_err = 1'b1;
        end
      end
      if (in_valid && was_full && ERR_EN) m_err = 1'b1;
      if (in_valid && !was_full) mq.push_back('{t: in_type, d: in_data});
    end
  end

  task automatic send(input logic [1:0] t, input logic [31:0] d);
    in_valid = 1'b1; in_type = t; in_data = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    int base, rbase;
    int unsigned s;
    rst = 1'b1; in_valid = 1'b0; in_type = '0; in_data = '0; grt = 1'b0;
    idle(2);
    check("reset in_ready", 64'(in_ready), 64'd1);
    check("reset req", 64'(req), 64'd0);
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset out_data", 64'(out_data), 64'd0);
    check("reset err", 64'(err), 64'd0);
    rst = 1'b0;
    idle(1);

    // single flit to port 2
    grt = 1'b1; base = log_q.size(); rbase = req_cnt; s = cyc;
    send(2'b11, 32'hDEAD_0004);
    idle(5);
    check("single fwd count", 64'(log_q.size() - base), 64'd1);
    if (log_q.size() > base) begin
      check("single latency", 64'(log_q[base].c - s), 64'd3);
      check("single port", 64'(log_q[base].p), 64'b00100);
      check("single type", 64'(log_q[base].t), 64'b11);
      check("single data", 64'(log_q[base].d), 64'hDEAD_0004);
    end
    check("single req cycles", 64'(req_cnt - rbase), 64'd1);
    check("single back idle req", 64'(req), 64'd0);

    // 4-flit packet to port 1
    base = log_q.size(); rbase = req_cnt;
    send(2'b00, 32'h0000_0002);
    send(2'b01, 32'h0000_0011);
    send(2'b01, 32'h0000_0022);
    send(2'b10, 32'h0000_0033);
    idle(6);
    check("pkt fwd count", 64'(log_q.size() - base), 64'd4);
    if (log_q.size() >= base + 4) begin
      check("pkt consecutive", 64'(log_q[base+3].c - log_q[base].c), 64'd3);
      check("pkt tail data", 64'(log_q[base+3].d), 64'h33);
      check("pkt tail type", 64'(log_q[base+3].t), 64'b10);
      check("pkt body port", 64'(log_q[base+1].p), 64'b00010);
    end
    check("pkt req cycles", 64'(req_cnt - rbase), 64'd4);
    check("pkt req after tail", 64'(req), 64'd0);

    // backpressure: grt low, 6 flits offered to a 4-deep FIFO
    do_reset();
    grt = 1'b0; base = log_q.size();
    send(2'b00, 32'hA000_0008);
    send(2'b01, 32'h0000_00B1);
    send(2'b01, 32'h0000_00B2);
    send(2'b01, 32'h0000_00B3);
    send(2'b01, 32'h0000_00B4);
    send(2'b10, 32'h0000_00C0);
    idle(4);
    check("bp in_ready low", 64'(in_ready), 64'd0);
    check("bp req held", 64'(req), 64'b01000);
    check("bp no fwd yet", 64'(log_q.size() - base), 64'd0);
    grt = 1'b1;
    idle(8);
    check("bp drained count", 64'(log_q.size() - base), 64'd4);
    if (log_q.size() >= base + 4) begin
      check("bp flit0", 64'(log_q[base].d), 64'hA000_0008);
      check("bp flit1", 64'(log_q[base+1].d), 64'hB1);
      check("bp flit3", 64'(log_q[base+3].d), 64'hB3);
    end
    check("bp in_ready after drain", 64'(in_ready), 64'd1);
    send(2'b10, 32'h0000_00C1);
    idle(4);
    check("bp tail count", 64'(log_q.size() - base), 64'd5);
    check("bp err", 64'(err), 64'(ERR_EN));

    // stray body in IDLE, then a real packet
    do_reset();
    grt = 1'b1; base = log_q.size();
    send(2'b01, 32'h0000_0055);
    send(2'b00, 32'h0000_0010);
    send(2'b10, 32'h0000_0066);
    idle(6);
    check("stray fwd count", 64'(log_q.size() - base), 64'd2);
    if (log_q.size() >= base + 2) begin
      check("stray head data", 64'(log_q[base].d), 64'h10);
      check("stray head port", 64'(log_q[base].p), 64'b10000);
      check("stray tail data", 64'(log_q[base+1].d), 64'h66);
    end
    check("stray err", 64'(err), 64'(ERR_EN));

    // head with a zero port vector
    do_reset();
    base = log_q.size(); rbase = req_cnt;
    send(2'b00, 32'h0000_00A0);
    idle(4);
    check("zero-port fwd count", 64'(log_q.size() - base), 64'd0);
    check("zero-port req cycles", 64'(req_cnt - rbase), 64'd0);
    check("zero-port err", 64'(err), 64'(ERR_EN));
    check("zero-port in_ready", 64'(in_ready), 64'd1);

    // async reset mid-packet
    do_reset();
    grt = 1'b0;
    send(2'b00, 32'h1234_0001);
    send(2'b01, 32'h0000_BEEF);
    idle(2);
    check("mid req locked", 64'(req), 64'b00001);
    check("mid in_ready", 64'(in_ready), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("async req cleared", 64'(req), 64'd0);
    check("async in_ready", 64'(in_ready), 64'd1);
    check("async out_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    grt = 1'b1; base = log_q.size();
    send(2'b11, 32'h0000_0002);
    idle(5);
    check("post-reset fwd count", 64'(log_q.size() - base), 64'd1);
    if (log_q.size() > base) begin
      check("post-reset port", 64'(log_q[base].p), 64'b00010);
      check("post-reset data", 64'(log_q[base].d), 64'h2);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/inbuf.md
# inbuf

Per-input-port wormhole buffer of the router; sits directly upstream of the output-port fixed-priority arbiter. Stores incoming flits in a small FIFO and latches the one-hot output-port vector from each head flit. Drives that vector as this input's request toward the arbiters until the packet's tail flit has been granted and forwarded. One instance per router input port (5 per router).

## Interface

- DEPTH, 4: FIFO entries; power of two, at least 2.
- DATA_W, 32: flit payload width; at least 5.

- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream flit present.
- in_type  in  2  flit type: 00 head, 01 body, 10 tail, 11 single (head+tail).
- in_data  in  DATA_W  payload; on head/single, bits [4:0] are the one-hot output port.
- in_ready  out  1  FIFO not full.
- req  out  5  one-hot request to the output arbiters (bit n = output port n).
- grt  in  1  this input granted in the current cycle by the requested output's arbiter.
- out_valid  out  1  forwarded flit valid (one cycle per flit).
- out_type  out  2  forwarded flit type.
- out_data  out  DATA_W  forwarded payload.
- out_port  out  5  latched route of the forwarded flit.
- err  out  1  sticky protocol-error flag (see Configuration).

## Operation

- FIFO: circular buffer of {type, data} with wrapping read/write pointers and a count of width clog2(DEPTH)+1.
- Push: in_valid & in_ready. Pop: req != 0 & grt.
- in_ready is combinational ~full from the registered count; it does not depend on a same-cycle pop.
- Push and pop in the same cycle leave count unchanged. Pointers wrap DEPTH-1 -> 0.
- State machine:
  - IDLE: req = 0.
    - FIFO head is head/single with a non-zero port vector: latch bits [4:0] into route, go to LOCKED.
    - FIFO head is body/tail, or head/single with port vector 0: discard that entry (pop without forwarding), stay in IDLE.
  - LOCKED: req = route while the FIFO is non-empty, else 0.
    - On pop: register the flit to out_* with out_valid = 1.
    - If the popped type is tail or single, go to IDLE.
- grt while req = 0 is ignored.
- in_valid while full: flit discarded and no state change, apart from err (see Configuration).
- Route stays locked across FIFO-empty gaps mid-packet; req drops to 0 during the gap.

## Timing

- Reset (async assert): count 0, pointers 0, state IDLE, route 0, req 0, out_valid 0, out_type 0, out_data 0, out_port 0, err 0; in_ready = 1 once count is 0.
- Head latency with immediate grant:
  - push at edge E0;
  - route latched at E1, req high in the cycle after E1;
  - pop at E2, out_valid high in the cycle after E2.
  - in_valid cycle to out_valid cycle: 3.
- Body/tail throughput: 1 flit per cycle while grt stays high and the FIFO is non-empty.
- out_valid is a single-cycle pulse per forwarded flit. out_* hold their last value when out_valid = 0.
- A discarded non-head entry in IDLE consumes one cycle per entry.
- A single flit returns to IDLE at the pop edge. The next head is latched no earlier than the following edge, giving one req-low cycle between packets.

## Configuration

- INBUF_ERR_CHECK_EN defined:
  - err is set (sticky until rst) on push while full.
  - err is set on discard of a body/tail flit in IDLE.
  - err is set on discard of a head/single flit with port vector 0.
- INBUF_ERR_CHECK_EN undefined: err tied 0. Discard behaviour is identical.

## Test plan

- Single flit, data[4:0]=5'b00100, grt tied 1 → req=5'b00100 for one cycle; out_valid 3 cycles after in_valid with out_port=00100, out_type=11; back to IDLE.
- 4-flit packet (head to port 1, 2 body, tail), grt held 1 → out_valid high 4 consecutive cycles; req=5'b00010 throughout; req=0 after the tail.
- grt low for 10 cycles, DEPTH=4, 6 flits offered → in_ready low after 4 pushes; count stays 4; after grt rises, flits drain in order with no loss of accepted flits.
- Body flit arriving in IDLE, then a valid head → body discarded with no out_valid; head forwarded normally; err=1 only with INBUF_ERR_CHECK_EN.
- Head with port vector 0 → discarded with req never asserted; err=1 with the macro, 0 without.
- rst asserted mid-packet (2 flits buffered) → all outputs and count cleared immediately; in_ready=1; next head is routed from IDLE.
